// File: rtl/motor_driver_if.sv
// Command/enable bundle between the navigation controller (master) and the
// H-bridge driver (slave).
interface motor_driver_if;
  logic stop_motor;
  logic front_motor;
  logic turn_left;
  logic turn_right;
  logic rotate;
  logic left_fwd;
  logic left_rev;
  logic right_fwd;
  logic right_rev;
  logic done;

  modport master (
    output stop_motor, front_motor, turn_left, turn_right, rotate,
    input  left_fwd, left_rev, right_fwd, right_rev, done
  );

  modport slave (
    input  stop_motor, front_motor, turn_left, turn_right, rotate,
    output left_fwd, left_rev, right_fwd, right_rev, done
  );
endinterface

// File: rtl/motor_driver.sv
// Timed H-bridge driver: priority command decode, dead time, PWM gating and
// manoeuvre timing with a level-held done flag.
//   state  | meaning
//   STOP   | all enables off, cmd_q = STOP
//   DEAD   | all enables off, dead-time down-counter running
//   FWD    | both wheels forward at DUTY_FWD, never completes
//   TL/TR  | one wheel forward at DUTY_TURN for TURN_CYCLES
//   ROT    | left fwd + right rev at DUTY_TURN for ROTATE_CYCLES
//   DONE   | all enables off, done held while command unchanged
module motor_driver #(
  parameter int PWM_PERIOD    = 4,
  parameter int DUTY_FWD      = 4,
  parameter int DUTY_TURN     = 2,
  parameter int TURN_CYCLES   = 8,
  parameter int ROTATE_CYCLES = 12,
  parameter int DEAD_CYCLES   = 2
) (
  input logic            clk,
  input logic            reset,
  motor_driver_if.slave  io_bus
);

  typedef enum logic [2:0] {S_STOP, S_DEAD, S_FWD, S_TL, S_TR, S_ROT, S_DONE} state_t;
  typedef enum logic [2:0] {C_STOP, C_FWD, C_TL, C_TR, C_ROT} cmd_t;

  localparam logic [7:0]  PWM_MAX  = 8'(PWM_PERIOD - 1);
  localparam logic [7:0]  DUTY_F   = 8'(DUTY_FWD);
  localparam logic [7:0]  DUTY_T   = 8'(DUTY_TURN);
  localparam logic [15:0] DEAD_LD  = 16'(DEAD_CYCLES);
  localparam logic [15:0] TURN_LD  = 16'(TURN_CYCLES);
  localparam logic [15:0] ROT_LD   = 16'(ROTATE_CYCLES);

  state_t      r_state;
  cmd_t        r_cmd_q;
  logic [15:0] r_timer;
  logic [7:0]  r_pwm;
  logic [3:0]  r_en;      // {left_fwd, left_rev, right_fwd, right_rev}
  logic        r_done;

  cmd_t        w_cmd;
  logic [7:0]  w_pwm_nxt;

  always_comb begin
    w_cmd = C_STOP;
    if (io_bus.stop_motor)       w_cmd = C_STOP;
    else if (io_bus.rotate)      w_cmd = C_ROT;
    else if (io_bus.turn_left)   w_cmd = C_TL;
    else if (io_bus.turn_right)  w_cmd = C_TR;
    else if (io_bus.front_motor) w_cmd = C_FWD;
  end

  assign w_pwm_nxt = (r_pwm >= PWM_MAX) ? 8'd0 : r_pwm + 8'd1;

  function automatic logic [3:0] drive_mask(cmd_t c);
    case (c)
      C_FWD:   return 4'b1010;
      C_TL:    return 4'b0010;
      C_TR:    return 4'b1000;
      C_ROT:   return 4'b1001;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [7:0] duty_of(cmd_t c);
    return (c == C_FWD) ? DUTY_F : DUTY_T;
  endfunction

  function automatic logic [15:0] len_of(cmd_t c);
    case (c)
      C_TL, C_TR: return TURN_LD;
      C_ROT:      return ROT_LD;
      default:    return 16'd0;
    endcase
  endfunction

  function automatic state_t state_of(cmd_t c);
    case (c)
      C_FWD:   return S_FWD;
      C_TL:    return S_TL;
      C_TR:    return S_TR;
      C_ROT:   return S_ROT;
      default: return S_STOP;
    endcase
  endfunction

  // Outputs are computed from the next state/PWM value so they are registered
  // in the same edge that changes state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_STOP;
      r_cmd_q <= C_STOP;
      r_timer <= 16'd0;
      r_pwm   <= 8'd0;
      r_en    <= 4'b0000;
      r_done  <= 1'b0;
    end else if (w_cmd == C_STOP) begin
      r_state <= S_STOP;
      r_cmd_q <= C_STOP;
      r_timer <= 16'd0;
      r_pwm   <= 8'd0;
      r_en    <= 4'b0000;
      r_done  <= 1'b0;
    end else if (w_cmd != r_cmd_q) begin
      r_state <= S_DEAD;
      r_cmd_q <= w_cmd;
      r_timer <= DEAD_LD;
      r_pwm   <= 8'd0;
      r_en    <= 4'b0000;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_DEAD: begin
          if (r_timer <= 16'd1) begin
            r_state <= state_of(r_cmd_q);
            r_timer <= len_of(r_cmd_q);
            r_pwm   <= 8'd0;
            r_en    <= drive_mask(r_cmd_q) & {4{8'd0 < duty_of(r_cmd_q)}};
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_FWD: begin
          r_pwm <= w_pwm_nxt;
          r_en  <= drive_mask(r_cmd_q) & {4{w_pwm_nxt < duty_of(r_cmd_q)}};
        end
        S_TL, S_TR, S_ROT: begin
          if (r_timer <= 16'd1) begin
            r_state <= S_DONE;
            r_timer <= 16'd0;
            r_en    <= 4'b0000;
            r_done  <= 1'b1;
          end else begin
            r_timer <= r_timer - 16'd1;
            r_pwm   <= w_pwm_nxt;
            r_en    <= drive_mask(r_cmd_q) & {4{w_pwm_nxt < duty_of(r_cmd_q)}};
          end
        end
        S_DONE: begin
          r_en   <= 4'b0000;
          r_done <= 1'b1;
        end
        default: begin
          r_state <= S_STOP;
          r_en    <= 4'b0000;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.left_fwd  = r_en[3];
  assign io_bus.left_rev  = r_en[2];
  assign io_bus.right_fwd = r_en[1];
  assign io_bus.right_rev = r_en[0];
  assign io_bus.done      = r_done;

endmodule

// File: tb/tb_motor_driver.sv
// Directed vector bench for motor_driver: table of per-edge {reset, command,
// expected outputs} plus hand sequences for abort and mid-rotate reset.
module tb_motor_driver;
  // Command bits {stop, rotate, turn_left, turn_right, front}
  localparam logic [4:0] C_NONE = 5'b00000;
  localparam logic [4:0] C_STP  = 5'b10000;
  localparam logic [4:0] C_ROT  = 5'b01000;
  localparam logic [4:0] C_TL   = 5'b00100;
  localparam logic [4:0] C_TR   = 5'b00010;
  localparam logic [4:0] C_FWD  = 5'b00001;
  // Output bits {left_fwd, left_rev, right_fwd, right_rev, done}
  localparam logic [4:0] O_OFF  = 5'b00000;
  localparam logic [4:0] O_FWD  = 5'b10100;
  localparam logic [4:0] O_TL   = 5'b00100;
  localparam logic [4:0] O_TR   = 5'b10000;
  localparam logic [4:0] O_ROT  = 5'b10010;
  localparam logic [4:0] O_DONE = 5'b00001;

  typedef struct {
    logic       rst;
    logic [4:0] cmd;
    logic [4:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  vec_t vq[$];

  motor_driver_if bus ();

  motor_driver dut (
    .clk    (clk),
    .reset  (reset),
    .io_bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic add(input logic r, input logic [4:0] c, input logic [4:0] e);
    vec_t v;
    v.rst = r;
    v.cmd = c;
    v.exp = e;
    vq.push_back(v);
  endtask

  // Manoeuvre drive pattern with DUTY_TURN=2 of PWM_PERIOD=4: on,on,off,off.
  task automatic add_drive(input logic [4:0] c, input logic [4:0] on, input int n);
    for (int i = 0; i < n; i++) add(1'b1, c, ((i % 4) < 2) ? on : O_OFF);
  endtask

  task automatic step(input logic r, input logic [4:0] c, input logic [4:0] e,
                      input string name, input int idx);
    logic [4:0] got;
    @(negedge clk);
    reset          = r;
    bus.stop_motor = c[4];
    bus.rotate     = c[3];
    bus.turn_left  = c[2];
    bus.turn_right = c[1];
    bus.front_motor = c[0];
    @(posedge clk);
    #1;
    got = {bus.left_fwd, bus.left_rev, bus.right_fwd, bus.right_rev, bus.done};
    n_tests++;
    if (got !== e) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b (lf lr rf rr done) expected %b", name, idx, got, e);
    end
  endtask

  initial begin
    reset = 1'b0;
    bus.stop_motor = 1'b0; bus.rotate = 1'b0; bus.turn_left = 1'b0;
    bus.turn_right = 1'b0; bus.front_motor = 1'b0;

    // Reset held with front_motor, then release: 2 dead cycles, then forward on.
    for (int i = 0; i < 3; i++) add(1'b0, C_FWD, O_OFF);
    add(1'b1, C_FWD, O_OFF);
    add(1'b1, C_FWD, O_OFF);
    for (int i = 0; i < 6; i++) add(1'b1, C_FWD, O_FWD);
    add(1'b1, C_NONE, O_OFF);
    // turn_left: dead, 8 drive cycles, done held, then dropped.
    add(1'b1, C_TL, O_OFF);
    add(1'b1, C_TL, O_OFF);
    add_drive(C_TL, O_TL, 8);
    for (int i = 0; i < 3; i++) add(1'b1, C_TL, O_DONE);
    add(1'b1, C_NONE, O_OFF);
    // rotate: dead, 12 drive cycles, done on edge 14.
    add(1'b1, C_ROT, O_OFF);
    add(1'b1, C_ROT, O_OFF);
    add_drive(C_ROT, O_ROT, 12);
    add(1'b1, C_ROT, O_DONE);
    add(1'b1, C_ROT, O_DONE);
    add(1'b1, C_NONE, O_OFF);
    // stop_motor overrides rotate; releasing it starts a normal rotate.
    for (int i = 0; i < 3; i++) add(1'b1, C_STP | C_ROT, O_OFF);
    add(1'b1, C_ROT, O_OFF);
    add(1'b1, C_ROT, O_OFF);
    add_drive(C_ROT, O_ROT, 12);
    add(1'b1, C_ROT, O_DONE);
    // Stop while in DONE clears done at the next edge.
    add(1'b1, C_STP | C_ROT, O_OFF);
    // Priority: turn_left beats turn_right and front.
    add(1'b1, C_TL | C_TR | C_FWD, O_OFF);
    add(1'b1, C_TL | C_TR | C_FWD, O_OFF);
    add(1'b1, C_TL | C_TR | C_FWD, O_TL);
    add(1'b1, C_NONE, O_OFF);

    for (int i = 0; i < vq.size(); i++)
      step(vq[i].rst, vq[i].cmd, vq[i].exp, "table", i);

    // Abort: turn_right for 4 drive cycles, then front_motor.
    step(1'b1, C_TR, O_OFF, "abort_dead", 0);
    step(1'b1, C_TR, O_OFF, "abort_dead", 1);
    for (int i = 0; i < 4; i++)
      step(1'b1, C_TR, ((i % 4) < 2) ? O_TR : O_OFF, "abort_tr", i);
    step(1'b1, C_FWD, O_OFF, "abort_switch", 0);
    step(1'b1, C_FWD, O_OFF, "abort_switch", 1);
    for (int i = 0; i < 8; i++) step(1'b1, C_FWD, O_FWD, "abort_fwd", i);
    step(1'b1, C_NONE, O_OFF, "abort_stop", 0);

    // Reset at rotate drive cycle 5, rotate kept high: full restart.
    step(1'b1, C_ROT, O_OFF, "rrst_dead", 0);
    step(1'b1, C_ROT, O_OFF, "rrst_dead", 1);
    for (int i = 0; i < 5; i++)
      step(1'b1, C_ROT, ((i % 4) < 2) ? O_ROT : O_OFF, "rrst_pre", i);
    step(1'b0, C_ROT, O_OFF, "rrst_reset", 0);
    step(1'b1, C_ROT, O_OFF, "rrst_dead2", 0);
    step(1'b1, C_ROT, O_OFF, "rrst_dead2", 1);
    for (int i = 0; i < 12; i++)
      step(1'b1, C_ROT, ((i % 4) < 2) ? O_ROT : O_OFF, "rrst_drive", i);
    step(1'b1, C_ROT, O_DONE, "rrst_done", 0);
    step(1'b1, C_TL, O_OFF, "rrst_change", 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/motor_driver.md
# motor_driver

Timed H-bridge driver placed directly downstream of the robot navigation controller. It decodes the controller's motion commands (`stop_motor`, `front_motor`, `turn_left`, `turn_right`, `rotate`) into PWM-gated enables for two wheel motors. It enforces dead time between drive changes, times turn and rotate manoeuvres, and returns the `done` flag the controller uses to leave its turn and rotate states.

## Interface
Parameters:
- `PWM_PERIOD`, 4: PWM period in clk cycles, ≥1, ≤255.
- `DUTY_FWD`, 4: high cycles per period in forward, 0..PWM_PERIOD.
- `DUTY_TURN`, 2: high cycles per period in turn/rotate, 0..PWM_PERIOD.
- `TURN_CYCLES`, 8: drive length of turn_left/turn_right, ≥1, <2^16.
- `ROTATE_CYCLES`, 12: drive length of rotate, ≥1, <2^16.
- `DEAD_CYCLES`, 2: all-off cycles before any new drive, ≥1, <2^16.

Ports:
- `clk`  in  1  single clock; everything updates on its rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `stop_motor`, `front_motor`, `turn_left`, `turn_right`, `rotate`  in  1 each  motion commands from the controller.
- `left_fwd`, `left_rev`, `right_fwd`, `right_rev`  out  1 each  registered H-bridge enables.
- `done`  out  1  registered; manoeuvre complete, held as a level.

## Operation
- Command decode uses fixed priority: stop_motor > rotate > turn_left > turn_right > front_motor. If no command is asserted, the decode is STOP.
- The decoded command is compared each cycle against `cmd_q`, the last accepted command.
- States:
  - STOP: all enables 0.
  - DEAD: all enables 0, dead-time timer running.
  - FWD: `left_fwd`, `right_fwd`, duty DUTY_FWD, no timer.
  - TL: `right_fwd` only, DUTY_TURN, TURN_CYCLES.
  - TR: `left_fwd` only, DUTY_TURN, TURN_CYCLES.
  - ROT: `left_fwd` + `right_rev`, DUTY_TURN, ROTATE_CYCLES.
  - DONE: all enables 0, `done`=1.
- Transitions:
  - Decoded STOP, from any state: go to STOP at the next edge.
  - Decoded drive command ≠ `cmd_q`: go to DEAD, load the timer with DEAD_CYCLES, and set `cmd_q`.
  - DEAD, timer expired: enter the drive state for `cmd_q`. Load the manoeuvre timer and clear the PWM counter.
  - TL/TR/ROT, manoeuvre timer expired: go to DONE.
  - DONE, command unchanged: stay in DONE. `done` stays high for as long as the command is held.
  - FWD never completes. `done` is always 0 in FWD.
- PWM:
  - 8-bit counter, 0..PWM_PERIOD-1, cleared to 0 on entry to each drive state.
  - Drive enables = state mask AND (pwm_cnt < duty).
  - duty = PWM_PERIOD gives always-on; duty = 0 gives always-off, but the timer still runs.
- Timers are 16-bit down-counters. A reverse enable is never high in the same cycle as the forward enable of the same wheel.
- A command change mid-manoeuvre aborts it: the block goes to DEAD (or STOP), and `done` is not asserted for the aborted manoeuvre.
- A command change while in DONE clears `done` at the same edge the block leaves DONE.
- Reset, at any time including mid-manoeuvre: at the next edge the state is STOP, `cmd_q`=STOP, timers and PWM counter are 0, and all outputs are 0.

## Timing
- All outputs are registered. Reset values: `left_fwd`=`left_rev`=`right_fwd`=`right_rev`=`done`=0.
- Command inputs are sampled at edge k:
  - STOP, or entry to DEAD, is visible on the outputs after edge k.
  - Drive enables go active after edge k+DEAD_CYCLES.
- A manoeuvre of N cycles (TURN_CYCLES or ROTATE_CYCLES) drives for exactly N cycles, starting at pwm_cnt=0.
- `done` rises on the edge that ends drive cycle N, i.e. after edge k+DEAD_CYCLES+N.
- `done` falls on the first edge that samples a changed command. The controller sees it as a level, so there is no lost pulse.
- Simultaneous commands resolve through the priority rule in the same cycle; no extra latency.

## Test plan
Default parameters are used throughout.
- Reset: hold `reset`=0 for 3 cycles with `front_motor`=1 → all outputs 0. After release: 2 cycles all 0, then `left_fwd`=`right_fwd`=1 continuously, `done`=0.
- turn_left from STOP → 2 dead cycles, then `right_fwd` = 1,1,0,0,1,1,0,0 with `left_*`=0. Next edge: `done`=1, held while `turn_left` is held. Drop to no command → `done`=0 at the next edge.
- rotate from STOP → 2 dead cycles, then 12 cycles of `left_fwd`=`right_rev` pattern 1100 with `left_rev`=`right_fwd`=0 always. `done`=1 after edge 14.
- Abort: turn_right, switch to `front_motor` after 4 drive cycles → 2 all-zero cycles, then both fwd enables at 1. `done` stays 0 throughout.
- Reset mid-rotate at drive cycle 5 → after the next edge all outputs are 0. After release with `rotate` still high, the 2-cycle dead time and the full 12-cycle rotate restart from the beginning.
- `stop_motor`=1 with `rotate`=1 → STOP wins: all outputs 0, `done`=0. Release `stop_motor` → normal rotate sequence.
